// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the 16-bit adder slice.
//   ADD_W  - operand and sum width in bits (fixed at 16)
//   word_t - one operand or sum word
// Imported by adder_16 and by the testbench.
package adder_pkg;

  localparam int ADD_W = 16;

  typedef logic [ADD_W-1:0] word_t;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// full_adder: a single one-bit full-adder cell, the building block of the
// ripple-carry chain in adder_16.
//   x, y  - operand bits
//   cin   - carry in from the next lower bit
//   s     - sum bit
//   cout  - carry out to the next higher bit
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = x ^ y;
  assign s        = half_sum ^ cin;
  // A carry is generated by x&y or propagated from cin when exactly one bit is set.
  assign cout     = (x & y) | (cin & half_sum);

endmodule : full_adder

// File: rtl/adder_16.sv
// adder_16: 16-bit two-operand adder with a registered sum and valid strobe.
// The sum wraps modulo 2^16 and is built from a ripple chain of full_adder cells.
//   clk       - sole clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - a and b are valid this cycle
//   a, b      - operands (unsigned or two's complement)
//   out_valid - out holds the result of operands captured one cycle earlier
//   out       - registered (a + b) mod 65536, held while in_valid is low
// Optional build macro ADDER_16_FLAGS_EN adds two registered flag outputs:
//   carry     - carry out of bit 15
//   ovf       - signed overflow
// Both flags update only on a capture edge.
module adder_16
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  word_t a,
  input  word_t b,
  output logic  out_valid,
  output word_t out
`ifdef ADDER_16_FLAGS_EN
  ,
  output logic  carry,
  output logic  ovf
`endif
);

  // The chain is hand-built for exactly 16 bits. Any other width is rejected
  // at elaboration rather than silently producing the wrong adder.
  if (WIDTH != ADD_W) begin : g_bad_width
    $error("adder_16: WIDTH must be 16");
  end

  word_t            sum;
  logic [ADD_W:0]   chain;

  word_t out_q, out_d;
  logic  out_valid_q, out_valid_d;

  assign chain[0] = 1'b0;

  for (genvar i = 0; i < ADD_W; i++) begin : g_ripple
    full_adder u_fa (
      .x    (a[i]),
      .y    (b[i]),
      .cin  (chain[i]),
      .s    (sum[i]),
      .cout (chain[i+1])
    );
  end

  // The sum is selected only when in_valid is high. Operands that are
  // don't-care while in_valid is low can therefore never reach out.
  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_d = sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef ADDER_16_FLAGS_EN
  logic carry_q, carry_d;
  logic ovf_q, ovf_d;

  // Signed overflow: both operands have the same sign but the sum does not.
  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      carry_d = chain[ADD_W];
      ovf_d   = (a[ADD_W-1] == b[ADD_W-1]) && (sum[ADD_W-1] != a[ADD_W-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign carry = carry_q;
  assign ovf   = ovf_q;
`else
  // Without the flags the final carry has no consumer.
  logic unused_carry_out;
  assign unused_carry_out = chain[ADD_W];
`endif

endmodule : adder_16

// File: tb/tb_adder_16.sv
// tb_adder_16: self-checking bench for adder_16.
// Expected results are computed by a behavioural 17-bit add when stimulus is
// driven, queued, and popped when the registered result appears.
// Define ADDER_16_FLAGS_EN to also check the carry and ovf outputs.
module tb_adder_16;
  import adder_pkg::*;

  logic  clk      = 1'b0;
  logic  rst      = 1'b1;
  logic  in_valid = 1'b0;
  word_t a        = '0;
  word_t b        = '0;
  logic  out_valid;
  word_t out;
`ifdef ADDER_16_FLAGS_EN
  logic  carry;
  logic  ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    word_t sum;
    logic  carry;
    logic  ovf;
  } exp_t;

  exp_t sb[$];

  adder_16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (out)
`ifdef ADDER_16_FLAGS_EN
    ,
    .carry     (carry),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain 17-bit addition, independent of the ripple chain.
  function automatic exp_t model(input word_t x, input word_t y);
    logic [16:0] full;
    exp_t        e;
    full    = {1'b0, x} + {1'b0, y};
    e.sum   = full[15:0];
    e.carry = full[16];
    e.ovf   = (x[15] == y[15]) && (full[15] != x[15]);
    return e;
  endfunction

  // Drive one cycle of operands, queue the expected result for valid cycles,
  // then step to just after the capturing edge.
  task automatic applyStimulus(input logic v, input word_t x, input word_t y);
    in_valid = v;
    a        = x;
    b        = y;
    if (v) sb.push_back(model(x, y));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_out: got %h want 0000", out);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b want 0", out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got out=%h valid=%b want 0000/0", out, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got out=%h valid=%b want 0000/0", out, out_valid);
    end
`ifdef ADDER_16_FLAGS_EN
    checks++;
    if (carry !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got carry=%b ovf=%b want 0/0", carry, ovf);
    end
`endif
  endtask

  // Directed vectors with their expected sum, carry and ovf written out by hand.
  task automatic test_vectors();
    word_t va[7]  = '{16'h0000, 16'h3CC3, 16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8001};
    word_t vb[7]  = '{16'hFFFF, 16'h0FF0, 16'h9876, 16'h0001, 16'h8000, 16'h0001, 16'hFFFF};
    word_t vs[7]  = '{16'hFFFF, 16'h4CB3, 16'hAAAA, 16'h0000, 16'h0000, 16'h8000, 16'h8000};
    logic  vc[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic  vo[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_t  e;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, va[i], vb[i]);
      e = sb.pop_front();
      checks++;
      if (out !== vs[i] || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL vector%0d: got out=%h valid=%b want %h/1", i, out, out_valid, vs[i]);
      end
      checks++;
      if (out !== e.sum) begin
        errors++;
        $display("[TB] FAIL vector%0d_model: got %h want %h", i, out, e.sum);
      end
`ifdef ADDER_16_FLAGS_EN
      checks++;
      if (carry !== vc[i] || ovf !== vo[i]) begin
        errors++;
        $display("[TB] FAIL vector%0d_flags: got carry=%b ovf=%b want %b/%b", i, carry, ovf, vc[i], vo[i]);
      end
`else
      if (vc[i] === 1'bx || vo[i] === 1'bx) $display("[TB] note: unset flag entry %0d", i);
`endif
    end
  endtask

  task automatic test_hold();
    exp_t e;
    applyStimulus(1'b1, 16'h1111, 16'h2222);
    e = sb.pop_front();
    checks++;
    if (out !== 16'h3333 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_capture: got out=%h valid=%b want 3333/1", out, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, word_t'($urandom), word_t'($urandom));
      checks++;
      if (out !== e.sum || out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold%0d: got out=%h valid=%b want %h/0", i, out, out_valid, e.sum);
      end
    end
    applyStimulus(1'b0, 'x, 'x);
    checks++;
    if (out !== e.sum || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_x: got out=%h valid=%b want %h/0", out, out_valid, e.sum);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, word_t'($urandom), word_t'($urandom));
      e = sb.pop_front();
      checks++;
      if (out !== e.sum || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b%0d: got out=%h valid=%b want %h/1", i, out, out_valid, e.sum);
      end
`ifdef ADDER_16_FLAGS_EN
      checks++;
      if (carry !== e.carry || ovf !== e.ovf) begin
        errors++;
        $display("[TB] FAIL b2b%0d_flags: got %b/%b want %b/%b", i, carry, ovf, e.carry, e.ovf);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_stream();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 16'h4000 + word_t'(i), 16'h0101);
      e = sb.pop_front();
      checks++;
      if (out !== e.sum || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL midrst_pre%0d: got out=%h valid=%b want %h/1", i, out, out_valid, e.sum);
      end
    end
    // This operand pair is in flight when reset hits and must be dropped.
    in_valid = 1'b1;
    a        = 16'h5555;
    b        = 16'h1111;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_async: got out=%h valid=%b want 0000/0", out, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_during: got out=%h valid=%b want 0000/0", out, out_valid);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_stale: got out=%h valid=%b want 0000/0", out, out_valid);
    end
    applyStimulus(1'b1, 16'h0F0F, 16'h0101);
    e = sb.pop_front();
    checks++;
    if (out !== 16'h1010 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_resume: got out=%h valid=%b want 1010/1", out, out_valid);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule : tb_adder_16

// File: doc/adder_16.md
Name: adder_16

Overview:
- 16-bit two-operand binary adder; sum wraps modulo 2^16.
- Registered output with a valid strobe, so it drops into clocked datapaths (ALU and PC-increment paths of the CPU).
- Sum logic is a ripple-carry chain of full-adder cells, matching the gate-up build style of the codebase.

Parameters:
- WIDTH, 16, operand and sum width in bits. Only 16 is supported. Elaboration fails for any other value.

Ports:
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, marks a and b as valid this cycle.
- a, input, 16, operand A, unsigned or two's complement.
- b, input, 16, operand B.
- out_valid, output, 1, out holds the result of the operands captured one cycle earlier.
- out, output, 16, registered sum (a + b) mod 65536.

Behaviour:
- Reset:
  - rst high forces out = 16'h0000 and out_valid = 0 immediately, independent of clk.
  - Both outputs hold these values while rst is asserted.
  - The first capture happens on the first rising edge after rst deasserts.
- Sum logic:
  - sum = a + b computed by a 16-stage ripple-carry chain.
  - Carry-in of bit 0 is 0.
  - Carry-out of bit 15 is discarded; no saturation.
- Capture:
  - On a rising edge with in_valid = 1: out <= sum; out_valid <= 1.
  - On a rising edge with in_valid = 0: out holds its previous value; out_valid <= 0.
- Latency: exactly 1 cycle from in_valid/operands to out_valid/out. Throughput is one result per cycle; back-to-back in_valid is legal.
- No backpressure: the consumer must accept out on the cycle out_valid is high.
- Signedness is irrelevant: the bit pattern is identical for signed and unsigned operands.
- Wrap-around examples:
  - 16'hFFFF + 16'h0001 = 16'h0000.
  - 16'h8000 + 16'h8000 = 16'h0000.
- Reset mid-operation: an in_valid pulse whose capture edge coincides with or follows rst assertion is dropped. out_valid stays 0.
- X on a or b while in_valid = 0 must not propagate to out.

Optional Feature:
- Macro: ADDER_16_FLAGS_EN.
- When defined, two extra registered outputs are added, updated only on a capture edge and reset to 0:
  - carry: 1 bit, carry-out of bit 15.
  - ovf: 1 bit, signed overflow, equal to (a[15] == b[15]) && (sum[15] != a[15]).
- When undefined:
  - Neither port exists.
  - The final carry is left unused and no flag logic is synthesised.
  - Port list and timing are otherwise identical.

Decomposition:
- Shared package adder_pkg holds:
  - localparam ADD_W = 16.
  - typedef logic [ADD_W-1:0] word_t, used for a, b, out and the internal sum.
- One sub-module, full_adder: inputs x, y, cin; outputs s, cout. It is instantiated 16 times in a generate loop to form the carry chain.
- The registers and valid logic stay in adder_16.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> out = 16'h0000 and out_valid = 0 immediately. Release rst -> both remain 0 until the first valid capture.
- Basic vectors, one per cycle with in_valid = 1. Each result must appear one cycle later with out_valid = 1:
  - 16'h0000 + 16'hFFFF -> 16'hFFFF.
  - 16'h3CC3 + 16'h0FF0 -> 16'h4CB3.
  - 16'h1234 + 16'h9876 -> 16'hAAAA.
- Wrap: 16'hFFFF + 16'h0001 -> out = 16'h0000. With flags enabled: carry = 1, ovf = 0.
- Signed overflow (flags enabled): 16'h7FFF + 16'h0001 -> out = 16'h8000, carry = 0, ovf = 1.
- Hold: after a capture, drive in_valid = 0 with random a and b for 3 cycles -> out unchanged and out_valid = 0.
- Reset mid-stream: back-to-back in_valid, assert rst between edges -> out and out_valid clear immediately. No stale result appears after release.
